unified_buffer_tiled: RTL and testbench

Parametrised on-chip unified buffer for the TPU datapath. It holds activations and results for an N×N systolic array. It serves three clients:
- single-cycle tile reads to the input-setup stage;
- gated tile writes from N accumulator channels;
- a streamed valid/ready burst readout to the host.

It generalises the fixed 2×2, 8-bit, 32-entry buffer to arbitrary data width, depth and array size, and adds a backpressure-aware host port with length, last and error signalling.

---
 rtl/unified_buffer_tiled.sv | 163 ++++++++++++++++
 tb/tb_unified_buffer_tiled.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_buffer_tiled.sv
// Unified on-chip buffer for an N x N systolic array.
// Serves single-cycle tile reads, gated tile writes from the accumulators,
// and a valid/ready burst readout to the host. All addressing wraps modulo DEPTH.
module unified_buffer_tiled #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int N      = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_req,
    input  logic [ADDR_W-1:0]        load_addr,
    output logic                     load_valid,
    output logic [N*N*DATA_W-1:0]    load_data,
    input  logic                     store_req,
    input  logic [ADDR_W-1:0]        store_addr,
    input  logic [N-1:0]             acc_full,
    input  logic [N*N*DATA_W-1:0]    acc_data,
    output logic                     store_ack,
    input  logic                     ext_req,
    input  logic [ADDR_W-1:0]        ext_addr,
    input  logic [ADDR_W:0]          ext_len,
    output logic                     ext_valid,
    input  logic                     ext_ready,
    output logic [DATA_W-1:0]        ext_data,
    output logic                     ext_last,
    output logic                     busy,
    output logic                     err
);

    localparam int              TILE    = N * N;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] TWO_L   = (ADDR_W + 1)'(2);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Base plus offset, truncated to the address width so it wraps at DEPTH.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                    input int off);
        wrap_addr = base + ADDR_W'(off);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic              store_fire;
    logic              len_ok;

    assign store_fire = store_req && (&acc_full);
    assign len_ok     = (ext_len != '0) && (ext_len <= DEPTH_L);

    // Memory array: cleared on reset, tile written only when every channel is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store_fire) begin
            for (int c = 0; c < N; c++) begin
                for (int j = 0; j < N; j++) begin
                    mem[wrap_addr(store_addr, c * N + j)] <= acc_data[(c * N + j) * DATA_W +: DATA_W];
                end
            end
        end else begin
            mem <= mem;
        end
    end

    // Tile read port: one-cycle latency, data held until the next request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_valid <= 1'b0;
            load_data  <= '0;
        end else begin
            load_valid <= load_req;
            if (load_req) begin
                for (int k = 0; k < TILE; k++) begin
                    load_data[k * DATA_W +: DATA_W] <= mem[wrap_addr(load_addr, k)];
                end
            end else begin
                load_data <= load_data;
            end
        end
    end

    // Store acknowledge pulse in the cycle after an accepted tile write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_ack <= 1'b0;
        end else begin
            store_ack <= store_fire;
        end
    end

    // Host burst FSM: word captured into ext_data when loaded, held under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            ext_valid <= 1'b0;
            ext_data  <= '0;
            ext_last  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ext_req && len_ok) begin
                        state     <= STREAM;
                        busy      <= 1'b1;
                        ptr       <= ext_addr;
                        remaining <= ext_len;
                        ext_valid <= 1'b1;
                        ext_data  <= mem[ext_addr];
                        ext_last  <= (ext_len == ONE_L);
                        err       <= 1'b0;
                    end else if (ext_req) begin
                        err <= 1'b1;
                    end else begin
                        err <= 1'b0;
                    end
                end
                STREAM: begin
                    err <= 1'b0;
                    if (ext_valid && ext_ready) begin
                        if (remaining > ONE_L) begin
                            ptr       <= wrap_addr(ptr, 1);
                            remaining <= remaining - ONE_L;
                            ext_data  <= mem[wrap_addr(ptr, 1)];
                            ext_last  <= (remaining == TWO_L);
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            remaining <= '0;
                            ext_valid <= 1'b0;
                            ext_data  <= '0;
                            ext_last  <= 1'b0;
                        end
                    end else begin
                        ptr <= ptr;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    remaining <= '0;
                    ext_valid <= 1'b0;
                    ext_data  <= '0;
                    ext_last  <= 1'b0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_buffer_tiled.sv
// Bench for unified_buffer_tiled: directed vector table, hand-written
// reset-mid-burst sequence, and random traffic against a word-level model.
module tb_unified_buffer_tiled;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic [5:0]  load_addr;
    logic        load_valid;
    logic [31:0] load_data;
    logic        store_req;
    logic [5:0]  store_addr;
    logic [1:0]  acc_full;
    logic [31:0] acc_data;
    logic        store_ack;
    logic        ext_req;
    logic [5:0]  ext_addr;
    logic [6:0]  ext_len;
    logic        ext_valid;
    logic        ext_ready;
    logic [7:0]  ext_data;
    logic        ext_last;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    unified_buffer_tiled #(.DATA_W(8), .DEPTH(64), .N(2)) dut (
        .clk(clk), .reset(reset),
        .load_req(load_req), .load_addr(load_addr),
        .load_valid(load_valid), .load_data(load_data),
        .store_req(store_req), .store_addr(store_addr),
        .acc_full(acc_full), .acc_data(acc_data), .store_ack(store_ack),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_len(ext_len),
        .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_data(ext_data),
        .ext_last(ext_last), .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (word-level) ----------------
    logic [7:0]  m_mem [DEPTH];
    logic        m_lv, m_sack, m_busy, m_valid, m_last, m_err;
    logic [31:0] m_ld;
    logic [7:0]  m_data;
    int          m_base, m_len, m_idx;
    logic [7:0]  rx [$];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_lv = 1'b0; m_sack = 1'b0; m_busy = 1'b0; m_valid = 1'b0;
        m_last = 1'b0; m_err = 1'b0; m_ld = 32'h0; m_data = 8'h00;
        m_base = 0; m_len = 0; m_idx = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        // reads see contents before this cycle's write
        m_lv = load_req;
        if (load_req)
            for (int k = 0; k < 4; k++) m_ld[k*8 +: 8] = m_mem[(int'(load_addr) + k) % DEPTH];
        m_sack = store_req && (acc_full == 2'b11);
        m_err = 1'b0;
        if (!m_busy) begin
            if (ext_req) begin
                if (ext_len == 7'd0 || int'(ext_len) > DEPTH) begin
                    m_err = 1'b1;
                end else begin
                    m_busy = 1'b1; m_valid = 1'b1;
                    m_base = int'(ext_addr); m_len = int'(ext_len); m_idx = 0;
                    m_data = m_mem[m_base];
                    m_last = (m_len == 1);
                end
            end
        end else if (ext_ready) begin
            if (m_idx + 1 < m_len) begin
                m_idx++;
                m_data = m_mem[(m_base + m_idx) % DEPTH];
                m_last = (m_idx == m_len - 1);
            end else begin
                m_busy = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_data = 8'h00;
            end
        end
        if (m_sack)
            for (int i = 0; i < 4; i++) m_mem[(int'(store_addr) + i) % DEPTH] = acc_data[i*8 +: 8];
    endtask

    task automatic compare_model();
        check("model_load_valid", load_valid, m_lv);
        check("model_load_data",  load_data,  m_ld);
        check("model_store_ack",  store_ack,  m_sack);
        check("model_ext_valid",  ext_valid,  m_valid);
        check("model_ext_data",   ext_data,   m_data);
        check("model_ext_last",   ext_last,   m_last);
        check("model_busy",       busy,       m_busy);
        check("model_err",        err,        m_err);
    endtask

    // One clock: record host handshakes, step model, sample after the edge.
    task automatic cycle();
        if (ext_valid && ext_ready) rx.push_back(ext_data);
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        load_req = 1'b0; load_addr = 6'd0; store_req = 1'b0; store_addr = 6'd0;
        acc_full = 2'b00; acc_data = 32'h0; ext_req = 1'b0; ext_addr = 6'd0;
        ext_len = 7'd0; ext_ready = 1'b0;
    endtask

    // Asynchronous reset applied away from the clock edge; outputs checked before any edge.
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        #2;
        model_reset();
        check("rst_load_valid", load_valid, 1'b0);
        check("rst_load_data",  load_data,  32'h0);
        check("rst_store_ack",  store_ack,  1'b0);
        check("rst_ext_valid",  ext_valid,  1'b0);
        check("rst_ext_data",   ext_data,   8'h00);
        check("rst_ext_last",   ext_last,   1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_err",        err,        1'b0);
        #2;
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        lr;  logic [5:0] la;
        logic        sr;  logic [5:0] sa; logic [1:0] af; logic [31:0] ad;
        logic        er;  logic [5:0] ea; logic [6:0] el; logic rdy;
        logic        x_lv; logic [31:0] x_ld; logic x_sack;
        logic        x_ev; logic [7:0] x_ed; logic x_last; logic x_busy; logic x_err;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input int unsigned lr, la, sr, sa, af, ad, er, ea, el, rdy,
                                input int unsigned lv, ld, sack, ev, ed, last, bsy, er_o);
        vec_t v;
        v.lr = 1'(lr); v.la = 6'(la); v.sr = 1'(sr); v.sa = 6'(sa); v.af = 2'(af);
        v.ad = 32'(ad); v.er = 1'(er); v.ea = 6'(ea); v.el = 7'(el); v.rdy = 1'(rdy);
        v.x_lv = 1'(lv); v.x_ld = 32'(ld); v.x_sack = 1'(sack); v.x_ev = 1'(ev);
        v.x_ed = 8'(ed); v.x_last = 1'(last); v.x_busy = 1'(bsy); v.x_err = 1'(er_o);
        return v;
    endfunction

    localparam int unsigned T = 32'h04030201;
    localparam int unsigned B = 32'h44332211;
    localparam int unsigned W = 32'hD4D3D2D1;

    initial begin
        logic [7:0] exp_words [4];
        int r;
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        //            lr la sr sa af ad  er ea el rdy | lv ld sk ev ed    lst bsy err
        tbl.push_back(mk(0, 0, 1, 8, 3, T, 0, 0, 0, 0,  0, 0, 1, 0, 0,    0, 0, 0));
        tbl.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 0,  1, T, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8, 1, B, 0, 0, 0, 0,  0, T, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 0,  1, T, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8, 4, 0,  0, T, 0, 1, 1,    0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, T, 0, 1, 2,    0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 0,  0, T, 0, 1, 2,    0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, T, 0, 1, 3,    0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, T, 0, 1, 4,    1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, T, 0, 1, 4,    1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, T, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, T, 0, 0, 0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, T, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 65,0,  0, T, 0, 0, 0,    0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, T, 0, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 62,3, W, 0, 0, 0, 0,  0, T, 1, 0, 0,    0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 62,4, 1,  0, T, 0, 1, 'hD1, 0, 1, 0));
        tbl.push_back(mk(1, 62,0, 0, 0, 0, 0, 0, 0, 1,  1, W, 0, 1, 'hD2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, W, 0, 1, 'hD3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, W, 0, 1, 'hD4, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, W, 0, 0, 0,    0, 0, 0));

        rx.delete();
        for (int i = 0; i < tbl.size(); i++) begin
            load_req = tbl[i].lr;  load_addr = tbl[i].la;
            store_req = tbl[i].sr; store_addr = tbl[i].sa;
            acc_full = tbl[i].af;  acc_data = tbl[i].ad;
            ext_req = tbl[i].er;   ext_addr = tbl[i].ea;
            ext_len = tbl[i].el;   ext_ready = tbl[i].rdy;
            cycle();
            check($sformatf("row%0d_load_valid", i), load_valid, tbl[i].x_lv);
            check($sformatf("row%0d_load_data", i),  load_data,  tbl[i].x_ld);
            check($sformatf("row%0d_store_ack", i),  store_ack,  tbl[i].x_sack);
            check($sformatf("row%0d_ext_valid", i),  ext_valid,  tbl[i].x_ev);
            check($sformatf("row%0d_ext_data", i),   ext_data,   tbl[i].x_ed);
            check($sformatf("row%0d_ext_last", i),   ext_last,   tbl[i].x_last);
            check($sformatf("row%0d_busy", i),       busy,       tbl[i].x_busy);
            check($sformatf("row%0d_err", i),        err,        tbl[i].x_err);
            if (i == 10) begin
                check("bp_burst_count", rx.size(), 4);
                for (int k = 0; k < 4 && k < rx.size(); k++)
                    check($sformatf("bp_burst_word%0d", k), rx[k], k + 1);
            end
        end
        idle_inputs();

        // ---------------- reset in the middle of a burst ----------------
        store_req = 1'b1; store_addr = 6'd20; acc_full = 2'b11; acc_data = 32'hA4A3A2A1;
        cycle();
        idle_inputs();
        ext_req = 1'b1; ext_addr = 6'd20; ext_len = 7'd4; ext_ready = 1'b1;
        cycle();
        ext_req = 1'b0;
        cycle();
        cycle();
        check("mid_before_reset_valid", ext_valid, 1'b1);
        do_reset();
        load_req = 1'b1; load_addr = 6'd20;
        cycle();
        check("mid_mem_cleared", load_data, 32'h0);
        idle_inputs();
        store_req = 1'b1; store_addr = 6'd20; acc_full = 2'b11; acc_data = 32'hB4B3B2B1;
        cycle();
        idle_inputs();
        rx.delete();
        ext_req = 1'b1; ext_addr = 6'd20; ext_len = 7'd4; ext_ready = 1'b1;
        cycle();
        ext_req = 1'b0;
        for (int c = 0; c < 5; c++) cycle();
        exp_words = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        check("fresh_burst_count", rx.size(), 4);
        for (int k = 0; k < 4 && k < rx.size(); k++)
            check($sformatf("fresh_burst_word%0d", k), rx[k], exp_words[k]);
        check("fresh_burst_busy_low", busy, 1'b0);

        // ---------------- random traffic against the model ----------------
        for (int c = 0; c < 2000; c++) begin
            load_req   = 1'($urandom_range(0, 1));
            load_addr  = 6'($urandom_range(0, 63));
            store_req  = 1'($urandom_range(0, 1));
            store_addr = 6'($urandom_range(0, 63));
            acc_full   = 2'($urandom_range(0, 3));
            acc_data   = $urandom;
            ext_req    = ($urandom_range(0, 3) == 0);
            ext_addr   = 6'($urandom_range(0, 63));
            r = int'($urandom_range(0, 9));
            if (r == 0)      ext_len = 7'd0;
            else if (r == 1) ext_len = 7'($urandom_range(65, 127));
            else if (r == 2) ext_len = 7'd64;
            else             ext_len = 7'($urandom_range(1, 8));
            ext_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
